// File: rtl/mult_hilo_ctrl.sv
// Sequencer and HI/LO holding stage around the iterative signed Booth multiplier.
// Freezes operands, resets the multiplier, counts 32 steps, then captures the product.
module mult_hilo_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wr_data,
  input  logic [31:0] mult_ms,
  input  logic [31:0] mult_ls,
  output logic        mult_rst,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, CAPT} state_t;

  localparam logic [5:0] LAST_STEP = 6'd31;

  state_t     state;
  logic [5:0] cnt;

  // busy and mult_rst are loaded with the value matching the next state, so
  // they are pure functions of the state register and never glitch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= 6'd0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      op_a     <= 32'd0;
      op_b     <= 32'd0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mult_rst <= 1'b1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Moves to HI/LO land even alongside start; CAPT overwrites them later.
          if (mthi) hi <= wr_data;
          if (mtlo) lo <= wr_data;
          if (start) begin
            op_a     <= src_a;
            op_b     <= src_b;
            state    <= LOAD;
            busy     <= 1'b1;
            mult_rst <= 1'b1;
          end
        end
        LOAD: begin
          cnt      <= 6'd0;
          state    <= RUN;
          mult_rst <= 1'b0;
        end
        RUN: begin
          cnt <= cnt + 6'd1;
          if (cnt == LAST_STEP) state <= CAPT;
        end
        CAPT: begin
          hi       <= mult_ms;
          lo       <= mult_ls;
          done     <= 1'b1;
          busy     <= 1'b0;
          mult_rst <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          mult_rst <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/mult_hilo_ctrl.md
# mult_hilo_ctrl

Sequencing and result-holding stage wrapped around the signed Booth multiplier of the datapath. It accepts a MULT request from the control unit and freezes the operands for the multiplier. It restarts the multiplier, counts its 32 iteration cycles, then captures the 64-bit product into the architectural HI/LO registers. It also services MTHI/MTLO writes and provides the busy/stall indication the CPU control FSM waits on.

## Interface
- No parameters; widths fixed: 32-bit operands, 64-bit product, 32 iterations.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  MULT request; sampled only in IDLE.
- src_a  in  32  multiplicand (rs), sampled with start.
- src_b  in  32  multiplier (rt), sampled with start.
- mthi  in  1  write wr_data into HI; honoured only in IDLE.
- mtlo  in  1  write wr_data into LO; honoured only in IDLE.
- wr_data  in  32  data for mthi/mtlo.
- mult_ms  in  32  multiplier product bits 63:32.
- mult_ls  in  32  multiplier product bits 31:0.
- mult_rst  out  1  reset to multiplier; high holds it at iteration 0.
- op_a  out  32  registered multiplicand to multiplier.
- op_b  out  32  registered multiplier operand to multiplier.
- hi  out  32  HI register, always readable (MFHI).
- lo  out  32  LO register, always readable (MFLO).
- busy  out  1  high while an operation is in flight; CPU stalls.
- done  out  1  one-cycle pulse when HI/LO take the product.

## Operation
- States: IDLE, LOAD, RUN, CAPT. Registered state; 6-bit iteration counter cnt.
- IDLE: if start, op_a<=src_a, op_b<=src_b, go LOAD. mthi/mtlo write HI/LO here. When start, mthi and mtlo coincide, HI/LO take wr_data now and are overwritten at CAPT.
- LOAD: one cycle. The multiplier sees mult_rst high on this edge and clears its count. cnt<=0. Go RUN.
- RUN: mult_rst low, and the multiplier performs one Booth step per edge. cnt increments each edge. On the edge where cnt==31 (32nd RUN edge), go CAPT.
- CAPT: hi<=mult_ms, lo<=mult_ls, done<=1 for the following cycle. Go IDLE.
- mult_rst is high in IDLE and LOAD and low in RUN and CAPT. It is decoded from the state register only, so it has no input-dependent glitches.
- busy is high in LOAD, RUN and CAPT, and low in IDLE.
- Product is signed two's complement 64-bit, as delivered by the multiplier; the block does no arithmetic on it.
- op_a and op_b hold their values from the LOAD edge until the next accepted start; they never change during RUN.
- Ignored while busy: start, mthi, mtlo, with no queuing. The CPU must hold or re-issue.
- Reset (async, any state, including mid-RUN):
  - state=IDLE, cnt=0.
  - hi=lo=op_a=op_b=0.
  - busy=0, done=0, mult_rst=1.
  - Any partial product is discarded.

## Timing
- Edge E1 samples start in IDLE. During the cycle after E1 the state is LOAD and busy=1.
- E2 is the multiplier reset edge. Edges E3–E34 are the 32 Booth steps.
- At E35 (CAPT), HI/LO update. done=1 and busy=0 during the cycle after E35.
- Latency from start sampled to HI/LO valid is 35 clock edges. Back-to-back: a new start is accepted at E36 at the earliest.
- mthi/mtlo in IDLE: HI/LO update on the same edge and are visible the next cycle.
- done is a single-cycle pulse. busy and done are never high in the same cycle.

## Test plan
- Reset mid-RUN: assert reset at E10 of an operation -> immediately hi=lo=0, busy=0, mult_rst=1. A following start then runs a full 35-edge sequence.
- Positive product: src_a=3, src_b=5, start -> busy high for exactly 34 cycles, done pulse after E35, hi=0x00000000, lo=0x0000000F.
- Signed product: src_a=3, src_b=0xFFFFFFFC (-4) -> hi=0xFFFFFFFF, lo=0xFFFFFFF4. Also 0x80000000×0x80000000 -> hi=0x40000000, lo=0x00000000.
- Operand freeze: change src_a/src_b every cycle during RUN -> op_a/op_b stay constant and the product matches the sampled values.
- Ignored requests: pulse start and mthi (wr_data=0xDEADBEEF) mid-RUN -> no restart, HI takes only the product. Then mthi in IDLE -> hi=0xDEADBEEF next cycle.
- Start+mtlo same cycle in IDLE (wr_data=0x1234, 2×2) -> lo=0x1234 next cycle, then lo=0x00000004 after E35.
